// File: rtl/mutative_types.sv
// ============================================================================
//  Module      : mutative_types (package)
//  Description : Shared types and constants for the cache dfp responder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mutative_types;

    // Byte-offset bits within a 32-byte line
    localparam int OFFSET_BITS = 5;

    // Width of one cache line on the dfp
    localparam int LINE_BITS = 256;

    // Responder sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dfp_state_t;

    // Operation carried by an accepted request
    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } dfp_op_t;

endpackage

`default_nettype wire

// File: rtl/dfp_line_store.sv
// ============================================================================
//  Module      : dfp_line_store
//  Description : Flop array of lines plus per-line written bits.
//                One combinational read port, one synchronous write port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dfp_line_store
    import mutative_types::*;
#(
    parameter int INDEX_BITS = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [LINE_BITS-1:0]  wr_data,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic [LINE_BITS-1:0]  rd_data,
    output logic                  rd_written
);

    localparam int DEPTH = 2 ** INDEX_BITS;

    logic [LINE_BITS-1:0] lines [DEPTH];
    logic [DEPTH-1:0]     written;

    // Line data is deliberately not reset; the written bit qualifies it
    always_ff @(posedge clk) begin
        if (wr_en) begin
            lines[wr_index] <= wr_data;
        end
    end

    // Written bits mark which lines hold real data since reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            written <= '0;
        end else if (wr_en) begin
            written[wr_index] <= 1'b1;
        end
    end

    assign rd_data    = lines[rd_index];
    assign rd_written = written[rd_index];

endmodule

`default_nettype wire

// File: rtl/dfp_line_responder.sv
// ============================================================================
//  Module      : dfp_line_responder
//  Description : Memory-side responder for a cache dfp port. Serves one
//                256-bit line read/write at a time with fixed latency,
//                stores written lines and flags protocol violations.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dfp_line_responder
    import mutative_types::*;
#(
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 4,
    parameter int INDEX_BITS    = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          dfp_addr,
    input  logic                 dfp_read,
    input  logic                 dfp_write,
    input  logic [LINE_BITS-1:0] dfp_wdata,
    output logic [LINE_BITS-1:0] dfp_rdata,
    output logic                 dfp_resp,
    output logic                 proto_err
);

    localparam int MAX_LAT    = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_BITS   = $clog2(MAX_LAT) + 1;
    localparam int LINE_WORDS = LINE_BITS / 32;

    dfp_state_t            state;
    dfp_state_t            state_next;
    logic [CNT_BITS-1:0]   cnt;
    logic [31:0]           cap_addr;
    dfp_op_t               cap_op;
    logic [LINE_BITS-1:0]  cap_wdata;

    logic                  accept;
    logic                  both_req;
    dfp_op_t               op_in;
    dfp_op_t               cur_op;
    logic [CNT_BITS-1:0]   lat_m1;
    logic [31:0]           src_addr;
    logic [31:0]           line_addr;
    logic                  enter_resp;
    logic                  mismatch;
    logic                  store_we;
    logic [LINE_BITS-1:0]  store_rdata;
    logic                  store_written;

    assign accept   = (state == IDLE) && (dfp_read ^ dfp_write);
    assign both_req = (state == IDLE) && dfp_read && dfp_write;
    assign op_in    = dfp_write ? WRITE : READ;
    assign lat_m1   = (op_in == WRITE) ? CNT_BITS'(WRITE_LATENCY - 1)
                                       : CNT_BITS'(READ_LATENCY - 1);

    // With LAT=1 the read data is loaded straight out of IDLE, before the
    // capture registers hold the address, so look up from the live bus there
    assign src_addr   = (state == IDLE) ? dfp_addr : cap_addr;
    assign cur_op     = (state == IDLE) ? op_in : cap_op;
    assign line_addr  = src_addr & ~32'((1 << OFFSET_BITS) - 1);
    assign enter_resp = (state_next == RESP) && (state != RESP);

    // Request must stay exactly as captured; wdata only matters for writes
    assign mismatch = ((cap_op == READ)  && !(dfp_read && !dfp_write)) ||
                      ((cap_op == WRITE) && !(dfp_write && !dfp_read)) ||
                      (dfp_addr != cap_addr) ||
                      ((cap_op == WRITE) && (dfp_wdata != cap_wdata));

    assign store_we = (state == RESP) && (cap_op == WRITE);

    dfp_line_store #(
        .INDEX_BITS (INDEX_BITS)
    ) u_store (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (store_we),
        .wr_index   (cap_addr[OFFSET_BITS +: INDEX_BITS]),
        .wr_data    (cap_wdata),
        .rd_index   (src_addr[OFFSET_BITS +: INDEX_BITS]),
        .rd_data    (store_rdata),
        .rd_written (store_written)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and response decode
    always_comb begin
        state_next = state;
        dfp_resp   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (lat_m1 != '0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (cnt == CNT_BITS'(1)) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                dfp_resp   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request capture and latency counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            cap_addr  <= '0;
            cap_op    <= READ;
            cap_wdata <= '0;
        end else if (accept) begin
            cnt       <= lat_m1;
            cap_addr  <= dfp_addr;
            cap_op    <= op_in;
            cap_wdata <= dfp_wdata;
        end else if (state == WAIT) begin
            cnt <= cnt - CNT_BITS'(1);
        end
    end

    // Read data loads on the edge entering RESP and then holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dfp_rdata <= '0;
        end else if (enter_resp && (cur_op == READ)) begin
            dfp_rdata <= store_written ? store_rdata : {LINE_WORDS{line_addr}};
        end
    end

    // Sticky protocol-violation flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            proto_err <= 1'b0;
        end else if (both_req ||
                     (accept && (dfp_addr[OFFSET_BITS-1:0] != '0)) ||
                     (((state == WAIT) || (state == RESP)) && mismatch)) begin
            proto_err <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dfp_line_responder.sv
// ============================================================================
//  Module      : tb_dfp_line_responder
//  Description : Self-checking bench for dfp_line_responder (table vectors,
//                randomized traffic against a line-memory model, corner cases).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dfp_line_responder;

    localparam int RL = 4;
    localparam int WL = 4;
    localparam int IB = 6;
    localparam int NLINES = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  dfp_addr  = '0;
    logic         dfp_read  = 1'b0;
    logic         dfp_write = 1'b0;
    logic [255:0] dfp_wdata = '0;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;
    logic         proto_err;

    int n_pass  = 0;
    int n_total = 0;

    dfp_line_responder #(
        .READ_LATENCY  (RL),
        .WRITE_LATENCY (WL),
        .INDEX_BITS    (IB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .dfp_addr  (dfp_addr),
        .dfp_read  (dfp_read),
        .dfp_write (dfp_write),
        .dfp_wdata (dfp_wdata),
        .dfp_rdata (dfp_rdata),
        .dfp_resp  (dfp_resp),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    // Reference memory: what each line should hold, and whether it was written
    logic [255:0] m_data [NLINES];
    bit           m_wr   [NLINES];

    function automatic int m_idx(input logic [31:0] a);
        return int'((a / 32) % NLINES);
    endfunction

    function automatic logic [255:0] m_read(input logic [31:0] a);
        logic [31:0] line;
        line = a - (a % 32);
        if (m_wr[m_idx(a)]) return m_data[m_idx(a)];
        return {8{line}};
    endfunction

    task automatic m_clear();
        for (int i = 0; i < NLINES; i++) m_wr[i] = 1'b0;
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        dfp_read  = 1'b0;
        dfp_write = 1'b0;
        rst = 1'b1;
        #1;
        step();
        step();
        rst = 1'b0;
        m_clear();
    endtask

    // One complete transaction; lat is the cycle (1-based) in which resp was seen
    task automatic do_txn(input bit wr, input logic [31:0] a, input logic [255:0] wd,
                          output int lat, output logic [255:0] rd);
        dfp_addr  = a;
        dfp_wdata = wd;
        dfp_read  = !wr;
        dfp_write = wr;
        lat = 1;
        while (dfp_resp !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        rd = dfp_rdata;
        step();
        dfp_read  = 1'b0;
        dfp_write = 1'b0;
        chk("resp_single_cycle", 256'(dfp_resp), 256'(0));
        if (wr) begin
            m_data[m_idx(a)] = wd;
            m_wr[m_idx(a)]   = 1'b1;
        end
    endtask

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        logic [255:0] exp_rdata;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int           lat;
        int           gap;
        int           nresp;
        logic [255:0] rd;
        logic [255:0] exp;
        logic [31:0]  a;
        logic [255:0] wd;
        bit           wr;

        m_clear();

        // Reset values before any clock edge
        rst = 1'b1;
        #2;
        chk("reset_resp", 256'(dfp_resp), 256'(0));
        chk("reset_rdata", dfp_rdata, 256'(0));
        chk("reset_proto_err", 256'(proto_err), 256'(0));
        step();
        step();
        rst = 1'b0;

        // Directed table
        tbl[0] = '{1'b0, 32'h0000_1040, 256'(0), {8{32'h0000_1040}}};
        tbl[1] = '{1'b1, 32'h0000_1040, {8{32'hDEAD_BEEF}}, 256'(0)};
        tbl[2] = '{1'b0, 32'h0000_1040, 256'(0), {8{32'hDEAD_BEEF}}};
        tbl[3] = '{1'b0, 32'h0000_1840, 256'(0), {8{32'hDEAD_BEEF}}};
        tbl[4] = '{1'b1, 32'hFFFF_F7E0, {8{32'h0123_4567}}, 256'(0)};
        tbl[5] = '{1'b0, 32'h0000_07E0, 256'(0), {8{32'h0123_4567}}};
        tbl[6] = '{1'b0, 32'h0000_0020, 256'(0), {8{32'h0000_0020}}};
        tbl[7] = '{1'b0, 32'h8000_1060, 256'(0), {8{32'h8000_1060}}};

        for (int i = 0; i < 8; i++) begin
            do_txn(tbl[i].wr, tbl[i].addr, tbl[i].wdata, lat, rd);
            chk($sformatf("tbl%0d_latency", i), 256'(lat), 256'(tbl[i].wr ? WL + 1 : RL + 1));
            if (!tbl[i].wr) chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
        end
        chk("tbl_proto_err", 256'(proto_err), 256'(0));

        // Randomized traffic over a few aliasing lines
        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom_range(0, 1));
            a  = (32'($urandom_range(0, 3)) << 11) | (32'($urandom_range(0, 7)) << 5);
            for (int w = 0; w < 8; w++) wd[w*32 +: 32] = $urandom;
            exp = m_read(a);
            do_txn(wr, a, wd, lat, rd);
            chk($sformatf("rnd%0d_latency", i), 256'(lat), 256'(wr ? WL + 1 : RL + 1));
            if (!wr) chk($sformatf("rnd%0d_rdata", i), rd, exp);
        end
        chk("rnd_proto_err", 256'(proto_err), 256'(0));

        // Back-to-back reads with the request held through RESP
        dfp_addr = 32'h0000_1040;
        dfp_read = 1'b1;
        exp = m_read(32'h0000_1040);
        lat = 1;
        while (dfp_resp !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        chk("b2b_first_latency", 256'(lat), 256'(RL + 1));
        gap = 0;
        do begin
            step();
            gap++;
        end while (dfp_resp !== 1'b1 && gap < 40);
        chk("b2b_gap", 256'(gap), 256'(RL + 1));
        chk("b2b_rdata", dfp_rdata, exp);
        step();
        dfp_read = 1'b0;

        // Misaligned address: completes on the line, flags error
        exp = m_read(32'h0000_1044);
        do_txn(1'b0, 32'h0000_1044, 256'(0), lat, rd);
        chk("misalign_latency", 256'(lat), 256'(RL + 1));
        chk("misalign_rdata", rd, exp);
        chk("misalign_proto_err", 256'(proto_err), 256'(1));
        do_reset();

        // Address changed mid-WAIT: original address still served
        dfp_addr = 32'h0000_1040;
        dfp_read = 1'b1;
        step();
        step();
        dfp_addr = 32'h0000_2080;
        lat = 3;
        while (dfp_resp !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        chk("addrchg_latency", 256'(lat), 256'(RL + 1));
        chk("addrchg_rdata", dfp_rdata, {8{32'h0000_1040}});
        step();
        dfp_read = 1'b0;
        chk("addrchg_proto_err", 256'(proto_err), 256'(1));
        do_reset();

        // Both request lines high: error, never a response
        dfp_addr  = 32'h0000_1040;
        dfp_read  = 1'b1;
        dfp_write = 1'b1;
        nresp = 0;
        for (int c = 0; c < 12; c++) begin
            if (dfp_resp === 1'b1) nresp++;
            step();
        end
        chk("both_no_resp", 256'(nresp), 256'(0));
        chk("both_proto_err", 256'(proto_err), 256'(1));
        do_reset();
        chk("rst_clears_proto_err", 256'(proto_err), 256'(0));

        // Reset in cycle 3 of a write: no response, no commit
        dfp_addr  = 32'h0000_1040;
        dfp_wdata = {8{32'hCAFE_F00D}};
        dfp_write = 1'b1;
        step();
        step();
        rst = 1'b1;
        #1;
        chk("rstwait_resp_now", 256'(dfp_resp), 256'(0));
        step();
        dfp_write = 1'b0;
        rst = 1'b0;
        m_clear();
        nresp = 0;
        for (int c = 0; c < 10; c++) begin
            if (dfp_resp === 1'b1) nresp++;
            step();
        end
        chk("rstwait_no_resp", 256'(nresp), 256'(0));
        do_txn(1'b0, 32'h0000_1040, 256'(0), lat, rd);
        chk("rstwait_read_latency", 256'(lat), 256'(RL + 1));
        chk("rstwait_read_rdata", rd, {8{32'h0000_1040}});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dfp_line_responder.md
# dfp_line_responder

Memory-side responder for the cache's downward-facing port (dfp). It accepts one 256-bit line read or write at a time from a cache's dfp initiator and answers with a single-cycle `dfp_resp` after a fixed, parameterised latency. It also stores the lines it is given and flags protocol violations. It serves as the backing memory for cache simulation and bring-up, standing where main memory would.

## Interface
- `READ_LATENCY`, default 4: cycles from request to `dfp_resp` for reads; must be at least 1.
- `WRITE_LATENCY`, default 4: the same, for writes; must be at least 1.
- `INDEX_BITS`, default 6: log2 of the number of stored lines.
- `clk` input 1: the only clock.
- `rst` input 1: asynchronous, active-high reset.
- `dfp_addr` input 32: line address; bits [4:0] are expected to be 0.
- `dfp_read` input 1: read request, held until `dfp_resp`.
- `dfp_write` input 1: write request, held until `dfp_resp`.
- `dfp_wdata` input 256: write line, held until `dfp_resp`.
- `dfp_rdata` output 256: read line; valid while `dfp_resp` is high.
- `dfp_resp` output 1: one-cycle completion pulse.
- `proto_err` output 1: sticky protocol-violation flag.

## Operation
- **Storage and valid bits.**
  - `2**INDEX_BITS` lines, indexed by `dfp_addr[5 +: INDEX_BITS]`. Upper address bits are ignored, so addresses alias.
  - Each line has a written bit, cleared by reset. Line data is not reset.
  - Reading a line that has never been written returns `{8{line_addr}}`, where `line_addr = {dfp_addr[31:5], 5'b0}`.
- **FSM states:** IDLE, WAIT, RESP.
- **IDLE.**
  - If exactly one of `dfp_read`/`dfp_write` is high: capture address, operation and wdata; load the counter with LAT−1.
  - Next state is WAIT if LAT > 1, otherwise RESP.
  - Both high: set `proto_err`, capture nothing, stay in IDLE.
- **WAIT.** Decrement the counter. When the counter equals 1, go to RESP on the next edge.
- **RESP.**
  - `dfp_resp` = 1.
  - A write commits the captured wdata and sets the written bit at the edge that leaves RESP.
  - Next state is always IDLE.
- **Read data.** For reads, `dfp_rdata` is loaded at the edge entering RESP and holds its value afterwards. It is 0 after reset.
- **`proto_err` sets** (sticky until `rst`) when any of these occur:
  - both request lines high in IDLE;
  - captured address bits [4:0] nonzero (the request still completes, with offset ignored);
  - in WAIT or RESP, the request is dropped, or the operation, address or wdata differs from what was captured (the response still completes using the captured values).
- **Ordering.** Commits happen in request order.
  - Read-after-write to the same line returns the new data.
  - A write in RESP and a read accepted in the following IDLE cycle do not conflict.

## Timing
- **Reset values:** `dfp_resp`=0, `dfp_rdata`=0, `proto_err`=0, state IDLE, all written bits 0. `rst` asserted mid-transaction aborts it immediately; there is no response and no commit.
- **Latency.** Count the first cycle a request is visible in IDLE as cycle 1. `dfp_resp` is high in cycle LAT+1 only, where LAT is `READ_LATENCY` or `WRITE_LATENCY`.
- **Back-to-back requests.** The cycle after RESP is IDLE. A request high in that cycle is a new request, so the sustained rate is one transaction per LAT+1 cycles.
- **Request lines during RESP.** The initiator may leave a request line high during RESP. This is not an error, because it is sampled only from IDLE.
- **Counter width** is `$clog2(max(READ_LATENCY,WRITE_LATENCY))+1`. The counter never wraps.

## Structure
- Add the following to `mutative_types`:
  - `dfp_state_t` (IDLE/WAIT/RESP);
  - `dfp_op_t` (READ/WRITE);
  - the constant `LINE_BITS`=256. `OFFSET_BITS`=5 already exists there; reuse it.
- Sub-module `dfp_line_store`: a flop array plus written bits, with one read port and one write port. The read-unwritten pattern is applied in the top level.

## Test plan
1. **Reset values:** assert `rst` with no clock edge → `dfp_resp`=0, `dfp_rdata`=0, `proto_err`=0.
2. **Unwritten read:** LAT=4, read 0x0000_1040 → `dfp_resp` high only in cycle 5, `dfp_rdata`={8{32'h0000_1040}}, `proto_err`=0.
3. **Write then read:** write 0x0000_1040 with {8{32'hDEADBEEF}}, then read the same address immediately after its resp → read returns {8{32'hDEADBEEF}}. Reading alias 0x0000_1840 (INDEX_BITS=6) returns the same data.
4. **Back-to-back:** read held high through RESP and the following cycle → second response arrives exactly LAT+1 cycles after the first.
5. **Protocol errors:**
   - `dfp_read` and `dfp_write` both high → `proto_err`=1, no `dfp_resp` ever.
   - `dfp_addr` changed mid-WAIT → `proto_err`=1, response still completes for the original address.
6. **Reset mid-WAIT:** `rst` pulsed in cycle 3 of a write → no `dfp_resp` appears; a later read of that line returns the unwritten pattern.
